multicycle_control_unit: RTL and testbench

//  Multi-cycle MIPS control FSM. Sequences the shared 32-bit ALU, register file, PC/IR and unified memory.

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/alu_op_decoder.sv | 47 ++++
 rtl/multicycle_control_unit.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, functs,
// ALU codes, datapath select encodings and the FSM state type.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_LW  = 4'd8;
  localparam logic [3:0] ALU_SW  = 4'd9;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_MEM_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  function automatic logic is_valid_funct(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation / immediate-extension decode from FSM state,
// opcode and funct.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       ext_zero
);

  always_comb begin
    alu_operation = ALU_AND;
    ext_zero      = 1'b0;
    case (state)
      S_FETCH, S_DECODE: alu_operation = ALU_ADD;
      S_EXEC_R: begin
        case (funct)
          FN_ADD:  alu_operation = ALU_ADD;
          FN_SUB:  alu_operation = ALU_SUB;
          FN_AND:  alu_operation = ALU_AND;
          FN_OR:   alu_operation = ALU_OR;
          FN_NOR:  alu_operation = ALU_NOR;
          FN_SLL:  alu_operation = ALU_SLL;
          FN_SRL:  alu_operation = ALU_SRL;
          default: alu_operation = ALU_AND;
        endcase
      end
      S_EXEC_I: begin
        case (opcode)
          OP_ADDI: alu_operation = ALU_ADD;
          OP_ORI: begin
            alu_operation = ALU_OR;
            ext_zero      = 1'b1;
          end
          OP_LUI:  alu_operation = ALU_LUI;
          default: alu_operation = ALU_AND;
        endcase
      end
      S_MEM_ADDR: alu_operation = (opcode == OP_SW) ? ALU_SW : ALU_LW;
      S_BRANCH:   alu_operation = ALU_SUB;
      default:    alu_operation = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register, memory wait counter with
// timeout, illegal-instruction flag and datapath control decode.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic [3:0] alu_operation,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);

  state_t             state, next_state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               illegal_q;
  logic               mem_state;
  logic               timeout;
  logic               illegal_dec;
  logic [3:0]         dec_op;
  logic               dec_ext_zero;

  alu_op_decoder u_alu_op_decoder (
    .state         (state),
    .opcode        (opcode),
    .funct         (funct),
    .alu_operation (dec_op),
    .ext_zero      (dec_ext_zero)
  );

  assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timeout   = (WAIT_LIMIT != 0) && mem_state && !mem_ready &&
                     (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  always_comb begin
    case (opcode)
      OP_RTYPE:                        illegal_dec = !is_valid_funct(funct);
      OP_LW, OP_SW, OP_ADDI, OP_ORI,
      OP_LUI, OP_BEQ, OP_BNE, OP_J:    illegal_dec = 1'b0;
      default:                         illegal_dec = 1'b1;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:     next_state = (mem_ready && !timeout) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (illegal_dec) next_state = S_FETCH;
        else begin
          case (opcode)
            OP_RTYPE:               next_state = S_EXEC_R;
            OP_LW, OP_SW:           next_state = S_MEM_ADDR;
            OP_ADDI, OP_ORI, OP_LUI: next_state = S_EXEC_I;
            OP_BEQ, OP_BNE:         next_state = S_BRANCH;
            OP_J:                   next_state = S_JUMP;
            default:                next_state = S_FETCH;
          endcase
        end
      end
      S_EXEC_R:    next_state = S_R_WB;
      S_EXEC_I:    next_state = S_I_WB;
      S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : (timeout ? S_FETCH : S_MEM_READ);
      S_MEM_WRITE: next_state = (timeout || mem_ready) ? S_FETCH : S_MEM_WRITE;
      default:     next_state = S_FETCH;
    endcase
  end

  // Any state change (or a timeout re-entering FETCH) starts a fresh wait count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      illegal_q <= (state == S_DECODE) && illegal_dec;
      if (next_state != state || timeout) wait_cnt <= '0;
      else if (mem_state && !mem_ready)   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_source     = PC_SRC_ALU;
    alu_operation = '0;
    ext_zero      = 1'b0;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;
    state_dbg     = state;
    // Reset forces every control low at once so no write can leak out.
    if (!reset) begin
      alu_operation = dec_op;
      ext_zero      = dec_ext_zero;
      illegal_instr = illegal_q;
      mem_timeout   = timeout;
      case (state)
        S_FETCH: begin
          mem_read  = !timeout;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:  alu_src_b = SRC_B_IMM_SH2;
        S_EXEC_R:  alu_src_a = 1'b1;
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
        end
        S_I_WB:    reg_write = 1'b1;
        S_MEM_READ: begin
          iord     = 1'b1;
          mem_read = !timeout;
        end
        S_MEM_WRITE: begin
          iord      = 1'b1;
          mem_write = !timeout;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_source = PC_SRC_ALUOUT;
          pc_write  = (opcode == OP_BEQ) ? zero : !zero;
        end
        S_JUMP: begin
          pc_source = PC_SRC_JUMP;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instruction classes,
// memory wait/timeout, illegal decode and asynchronous reset.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, ext_zero, illegal_instr, mem_timeout;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_operation, state_dbg;
  logic [19:0] ctl;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.WAIT_LIMIT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_source(pc_source),
    .alu_operation(alu_operation), .illegal_instr(illegal_instr),
    .mem_timeout(mem_timeout), .state_dbg(state_dbg)
  );

  assign ctl = {pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, ext_zero, pc_source, alu_operation,
                illegal_instr, mem_timeout};

  function automatic logic [19:0] c(input logic pcw, input logic io, input logic mr,
                                    input logic mw, input logic irw, input logic m2r,
                                    input logic rd, input logic rw, input logic asa,
                                    input logic [1:0] asb, input logic ez,
                                    input logic [1:0] pcs, input logic [3:0] op,
                                    input logic ill, input logic to);
    return {pcw, io, mr, mw, irw, m2r, rd, rw, asa, asb, ez, pcs, op, ill, to};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [19:0] ce);
    #1;
    check({tag, "_state"}, {28'd0, state_dbg}, {28'd0, st});
    check({tag, "_ctl"}, {12'd0, ctl}, {12'd0, ce});
    @(posedge clk);
    #2;
  endtask

  logic [19:0] F_RDY, F_NR, DEC;

  initial begin
    F_RDY = c(1,0,1,0,1,0,0,0,0,2'b01,0,2'b00,4'd3,0,0);
    F_NR  = c(0,0,1,0,0,0,0,0,0,2'b01,0,2'b00,4'd3,0,0);
    DEC   = c(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,4'd3,0,0);

    reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    #12;
    check("rst_ctl", {12'd0, ctl}, 32'd0);
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // add
    expect_st("add_fetch", 4'd0, F_RDY);
    expect_st("add_decode", 4'd1, DEC);
    expect_st("add_exec", 4'd2, c(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,4'd3,0,0));
    expect_st("add_wb", 4'd3, c(0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,4'd0,0,0));

    // lw with three wait cycles
    opcode = 6'h23;
    expect_st("lw_fetch", 4'd0, F_RDY);
    expect_st("lw_decode", 4'd1, DEC);
    mem_ready = 1'b0;
    expect_st("lw_addr", 4'd6, c(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'd8,0,0));
    for (int i = 0; i < 3; i++)
      expect_st("lw_wait", 4'd7, c(0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,4'd0,0,0));
    mem_ready = 1'b1;
    expect_st("lw_read", 4'd7, c(0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,4'd0,0,0));
    expect_st("lw_wb", 4'd9, c(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,4'd0,0,0));

    // beq taken, bne not taken, both with zero=1
    opcode = 6'h04; zero = 1'b1;
    expect_st("beq_fetch", 4'd0, F_RDY);
    expect_st("beq_decode", 4'd1, DEC);
    expect_st("beq_branch", 4'd10, c(1,0,0,0,0,0,0,0,1,2'b00,0,2'b01,4'd4,0,0));
    opcode = 6'h05;
    expect_st("bne_fetch", 4'd0, F_RDY);
    expect_st("bne_decode", 4'd1, DEC);
    expect_st("bne_branch", 4'd10, c(0,0,0,0,0,0,0,0,1,2'b00,0,2'b01,4'd4,0,0));
    zero = 1'b0;

    // ori, lui
    opcode = 6'h0D;
    expect_st("ori_fetch", 4'd0, F_RDY);
    expect_st("ori_decode", 4'd1, DEC);
    expect_st("ori_exec", 4'd4, c(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,4'd1,0,0));
    expect_st("ori_wb", 4'd5, c(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,4'd0,0,0));
    opcode = 6'h0F;
    expect_st("lui_fetch", 4'd0, F_RDY);
    expect_st("lui_decode", 4'd1, DEC);
    expect_st("lui_exec", 4'd4, c(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'd5,0,0));
    expect_st("lui_wb", 4'd5, c(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,4'd0,0,0));

    // illegal opcode, then illegal R funct, then jump
    opcode = 6'h3F;
    expect_st("ill_op_fetch", 4'd0, F_RDY);
    expect_st("ill_op_decode", 4'd1, DEC);
    opcode = 6'h00; funct = 6'h18;
    expect_st("ill_op_flag", 4'd0, c(1,0,1,0,1,0,0,0,0,2'b01,0,2'b00,4'd3,1,0));
    expect_st("ill_fn_decode", 4'd1, DEC);
    opcode = 6'h02;
    expect_st("ill_fn_flag", 4'd0, c(1,0,1,0,1,0,0,0,0,2'b01,0,2'b00,4'd3,1,0));
    expect_st("j_decode", 4'd1, DEC);
    expect_st("j_jump", 4'd11, c(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,4'd0,0,0));

    // sw aborted by reset while in MEM_WRITE
    opcode = 6'h2B;
    expect_st("sw_fetch", 4'd0, F_RDY);
    expect_st("sw_decode", 4'd1, DEC);
    mem_ready = 1'b0;
    expect_st("sw_addr", 4'd6, c(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'd9,0,0));
    #1;
    check("sw_write_ctl", {12'd0, ctl}, {12'd0, c(0,1,0,1,0,0,0,0,0,2'b00,0,2'b00,4'd0,0,0)});
    reset = 1'b1;
    #1;
    check("sw_rst_ctl", {12'd0, ctl}, 32'd0);
    check("sw_rst_state", {28'd0, state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // fetch timeout after 16 cycles with mem_ready low
    for (int i = 1; i <= 15; i++)
      expect_st("to_wait", 4'd0, F_NR);
    expect_st("to_fire", 4'd0, c(0,0,0,0,0,0,0,0,0,2'b01,0,2'b00,4'd3,0,1));
    expect_st("to_after", 4'd0, F_NR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
